// File: rtl/tkx_pkg.sv
// Shared types and sizing helpers for the tweakey bank.
package tkx_pkg;

    // Load controller states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } tkx_state_e;

    // Width of one tweakey plane.
    localparam int PLANE_W = 128;

    // Number of serial beats needed to fill one plane.
    function automatic int tkx_words(input int bus_w);
        return PLANE_W / bus_w;
    endfunction

    // Beat counter width; a single-beat load still keeps a 1-bit counter.
    function automatic int tkx_cnt_w(input int bus_w);
        int w;
        w = tkx_words(bus_w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

    // Low bit index of plane p inside an N_TK*128 packed vector.
    function automatic int tkx_plane_lo(input int p);
        return p * PLANE_W;
    endfunction

endpackage

// File: rtl/tkx_plane_reg.sv
// One 128-bit tweakey plane: serial shift-in or parallel forward/revert load.
// Word 0 is the least significant BUS_W slice and receives each new beat, so the
// first beat of a full load ends up in the most significant word.
module tkx_plane_reg
    import tkx_pkg::*;
#(
    parameter int BUS_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_shift_en,
    input  logic [BUS_W-1:0]   i_sdi,
    input  logic               i_fwd_en,
    input  logic [127:0]       i_fwd,
    input  logic               i_rev_en,
    input  logic [127:0]       i_rev,
    output logic [127:0]       o_plane
);

    localparam int WORDS = tkx_words(BUS_W);

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            logic [BUS_W-1:0] r_word;
            logic [BUS_W-1:0] w_shift_in;

            if (gi == 0) begin : g_head
                assign w_shift_in = i_sdi;
            end else begin : g_tail
                assign w_shift_in = g_word[gi-1].r_word;
            end

            // Word register: shift has priority; the controller never overlaps it with a parallel load.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_word <= '0;
                end else if (i_shift_en) begin
                    r_word <= w_shift_in;
                end else if (i_fwd_en) begin
                    r_word <= i_fwd[gi*BUS_W +: BUS_W];
                end else if (i_rev_en) begin
                    r_word <= i_rev[gi*BUS_W +: BUS_W];
                end
            end

            assign o_plane[gi*BUS_W +: BUS_W] = r_word;
        end
    endgenerate

endmodule

// File: rtl/tkx_bank_update.sv
// Tweakey state bank: N_TK planes with serial load controller and parallel
// forward/revert update from the SKINNY key schedule.
module tkx_bank_update
    import tkx_pkg::*;
#(
    parameter int BUS_W = 32,
    parameter int N_TK  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_W-1:0]     sdi,
    input  logic                 sdi_valid,
    output logic                 sdi_ready,
    input  logic                 ld_start,
    input  logic [1:0]           ld_sel,
    input  logic                 ld_abort,
    output logic                 ld_done,
    input  logic                 upd,
    input  logic                 rev,
    input  logic [N_TK*128-1:0]  skinny_tkx,
    input  logic [N_TK*128-1:0]  skinny_tkx_revert,
    output logic [N_TK*128-1:0]  tkx,
    output logic                 busy,
    output logic                 err
);

    localparam int             WORDS     = tkx_words(BUS_W);
    localparam int             CW        = tkx_cnt_w(BUS_W);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(WORDS - 1);
    localparam logic [2:0]     N_SEL     = 3'(N_TK);

    tkx_state_e     r_state;
    tkx_state_e     w_state_next;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_next;
    logic [1:0]     r_sel;
    logic [1:0]     w_sel_next;
    logic           r_done;
    logic           w_done_next;
    logic           r_err;
    logic           w_err_next;
    logic           w_shift;
    logic           w_fwd_en;
    logic           w_rev_en;

    // Controller state, beat counter, latched target and registered pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_sel   <= w_sel_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
        end
    end

    // Next-state logic: abort beats a coincident final beat, and parallel
    // updates are only honoured while idle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sel_next   = r_sel;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        w_shift      = 1'b0;
        w_fwd_en     = 1'b0;
        w_rev_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (upd && rev) begin
                    w_err_next = 1'b1;
                end else begin
                    w_fwd_en = upd;
                    w_rev_en = rev;
                end
                if (ld_start) begin
                    if ({1'b0, ld_sel} < N_SEL) begin
                        w_state_next = LOAD;
                        w_cnt_next   = '0;
                        w_sel_next   = ld_sel;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (ld_abort) begin
                    w_state_next = IDLE;
                end else if (sdi_valid) begin
                    w_shift    = 1'b1;
                    w_cnt_next = r_cnt + CW'(1);
                    if (r_cnt == LAST_BEAT) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                        w_cnt_next   = '0;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_TK; gi++) begin : g_plane
            logic w_shift_en;
            assign w_shift_en = w_shift && (r_sel == 2'(gi));

            tkx_plane_reg #(
                .BUS_W(BUS_W)
            ) u_plane (
                .clk        (clk),
                .rst        (rst),
                .i_shift_en (w_shift_en),
                .i_sdi      (sdi),
                .i_fwd_en   (w_fwd_en),
                .i_fwd      (skinny_tkx[tkx_plane_lo(gi) +: 128]),
                .i_rev_en   (w_rev_en),
                .i_rev      (skinny_tkx_revert[tkx_plane_lo(gi) +: 128]),
                .o_plane    (tkx[tkx_plane_lo(gi) +: 128])
            );
        end
    endgenerate

    assign sdi_ready = (r_state == LOAD);
    assign busy      = (r_state == LOAD);
    assign ld_done   = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_tkx_bank_update.sv
module tb_tkx_bank_update;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  sdi;
    logic         sdi_valid;
    logic         sdi_ready;
    logic         ld_start;
    logic [1:0]   ld_sel;
    logic         ld_abort;
    logic         ld_done;
    logic         upd;
    logic         rev;
    logic [383:0] skinny_tkx;
    logic [383:0] skinny_tkx_revert;
    logic [383:0] tkx;
    logic         busy;
    logic         err;

    // Second bank with two planes for the out-of-range select case.
    logic [31:0]  b_sdi;
    logic         b_sdi_valid;
    logic         b_sdi_ready;
    logic         b_ld_start;
    logic [1:0]   b_ld_sel;
    logic         b_ld_abort;
    logic         b_ld_done;
    logic         b_upd;
    logic         b_rev;
    logic [255:0] b_skinny_tkx;
    logic [255:0] b_skinny_tkx_revert;
    logic [255:0] b_tkx;
    logic         b_busy;
    logic         b_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [383:0] exp_q[$];
    logic [383:0] model;
    logic [383:0] exp_v;

    localparam logic [127:0] D1 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] D3 = 128'hAAAA0001_BBBB0002_CCCC0003_DDDD0004;

    always #5 clk = ~clk;

    tkx_bank_update #(.BUS_W(32), .N_TK(3)) dut (
        .clk(clk), .rst(rst), .sdi(sdi), .sdi_valid(sdi_valid), .sdi_ready(sdi_ready),
        .ld_start(ld_start), .ld_sel(ld_sel), .ld_abort(ld_abort), .ld_done(ld_done),
        .upd(upd), .rev(rev), .skinny_tkx(skinny_tkx), .skinny_tkx_revert(skinny_tkx_revert),
        .tkx(tkx), .busy(busy), .err(err)
    );

    tkx_bank_update #(.BUS_W(32), .N_TK(2)) dut2 (
        .clk(clk), .rst(rst), .sdi(b_sdi), .sdi_valid(b_sdi_valid), .sdi_ready(b_sdi_ready),
        .ld_start(b_ld_start), .ld_sel(b_ld_sel), .ld_abort(b_ld_abort), .ld_done(b_ld_done),
        .upd(b_upd), .rev(b_rev), .skinny_tkx(b_skinny_tkx), .skinny_tkx_revert(b_skinny_tkx_revert),
        .tkx(b_tkx), .busy(b_busy), .err(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one serial load; counts busy cycles and ld_done pulses as seen.
    task automatic run_load(input logic [1:0] sel, input logic [127:0] data, input bit gaps,
                            input int abort_at, output int busy_cyc, output int done_cnt);
        int beats;
        beats    = 0;
        busy_cyc = 0;
        done_cnt = 0;
        ld_sel   = sel;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || sdi_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_start_ready: busy=%b sdi_ready=%b required 1/1", busy, sdi_ready);
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (ld_done === 1'b1) done_cnt++;
            if (busy !== 1'b1) break;
            busy_cyc++;
            sdi_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            sdi       = (sdi_valid && beats < 4) ? data[127-32*beats -: 32] : 32'hDEADBEEF;
            ld_abort  = (abort_at >= 0 && beats == abort_at);
            tick();
            if (sdi_valid && !ld_abort) beats++;
            sdi_valid = 1'b0;
            ld_abort  = 1'b0;
        end
        tick();
        if (ld_done === 1'b1) done_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sdi = '0; sdi_valid = 0; ld_start = 0; ld_sel = 0; ld_abort = 0;
        upd = 0; rev = 0; skinny_tkx = '0; skinny_tkx_revert = '0;
        b_sdi = '0; b_sdi_valid = 0; b_ld_start = 0; b_ld_sel = 0; b_ld_abort = 0;
        b_upd = 0; b_rev = 0; b_skinny_tkx = '0; b_skinny_tkx_revert = '0;
        model = '0;
        repeat (3) tick();
        n_checks++;
        if (tkx !== 384'h0) begin n_fail++; $display("FAIL reset_tkx: got %h required 0", tkx); end
        n_checks++;
        if ({sdi_ready, busy, ld_done, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/busy/done/err=%b required 0000", {sdi_ready, busy, ld_done, err});
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++;
        if ({sdi_ready, busy, err} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_ctrl: ready/busy/err=%b required 000", {sdi_ready, busy, err});
        end
        $display("reset: tkx=0 outputs idle");
    endtask

    task automatic test_load(input logic [1:0] sel, input logic [127:0] data, input bit gaps,
                             input int req_busy, input string tag);
        int bc, dc;
        model[sel*128 +: 128] = data;
        exp_q.push_back(model);
        run_load(sel, data, gaps, -1, bc, dc);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (tkx !== exp_v) begin n_fail++; $display("FAIL %s_tkx: got %h required %h", tag, tkx, exp_v); end
        n_checks++;
        if (bc !== req_busy) begin n_fail++; $display("FAIL %s_busy: got %0d cycles required %0d", tag, bc, req_busy); end
        n_checks++;
        if (dc !== 1) begin n_fail++; $display("FAIL %s_done: got %0d pulses required 1", tag, dc); end
        $display("%s: plane %0d = %h busy=%0d done=%0d", tag, sel, tkx[sel*128 +: 128], bc, dc);
    endtask

    task automatic test_back_to_back();
        upd = 1'b1; skinny_tkx = {48{8'hA5}};
        exp_q.push_back({48{8'hA5}});
        tick();
        upd = 1'b0; rev = 1'b1; skinny_tkx_revert = {48{8'h5A}};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (tkx !== exp_v) begin n_fail++; $display("FAIL upd_tkx: got %h required %h", tkx, exp_v); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL upd_err: got %b required 0", err); end
        $display("upd: tkx=%h", tkx);
        exp_q.push_back({48{8'h5A}});
        tick();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (tkx !== exp_v) begin n_fail++; $display("FAIL rev_tkx: got %h required %h", tkx, exp_v); end
        $display("rev: tkx=%h", tkx);
        upd = 1'b1; rev = 1'b1; skinny_tkx = {48{8'h3C}}; skinny_tkx_revert = {48{8'hC3}};
        exp_q.push_back({48{8'h5A}});
        tick();
        upd = 1'b0; rev = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (tkx !== exp_v) begin n_fail++; $display("FAIL both_tkx: got %h required %h", tkx, exp_v); end
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL both_err: got %b required 1", err); end
        tick();
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL both_err_pulse: got %b required 0", err); end
        $display("upd+rev: tkx unchanged, err pulse");
        model = {48{8'h5A}};
    endtask

    task automatic test_abort(input logic [1:0] sel, input int abort_at, input logic [127:0] exp_plane,
                              input string tag);
        int bc, dc;
        model[sel*128 +: 128] = exp_plane;
        exp_q.push_back(model);
        run_load(sel, D3, 1'b0, abort_at, bc, dc);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (tkx !== exp_v) begin n_fail++; $display("FAIL %s_tkx: got %h required %h", tag, tkx, exp_v); end
        n_checks++;
        if (bc !== abort_at + 1) begin n_fail++; $display("FAIL %s_busy: got %0d required %0d", tag, bc, abort_at + 1); end
        n_checks++;
        if (dc !== 0) begin n_fail++; $display("FAIL %s_done: got %0d pulses required 0", tag, dc); end
        $display("%s: plane %0d = %h busy=%0d done=%0d", tag, sel, tkx[sel*128 +: 128], bc, dc);
    endtask

    task automatic test_illegal_sel();
        ld_sel = 2'd3; ld_start = 1'b1;
        b_ld_sel = 2'd2; b_ld_start = 1'b1;
        tick();
        ld_start = 1'b0; b_ld_start = 1'b0;
        n_checks++;
        if ({err, busy, sdi_ready} !== 3'b100) begin
            n_fail++; $display("FAIL sel3_n3: err/busy/ready=%b required 100", {err, busy, sdi_ready});
        end
        n_checks++;
        if ({b_err, b_busy, b_sdi_ready} !== 3'b100) begin
            n_fail++; $display("FAIL sel2_n2: err/busy/ready=%b required 100", {b_err, b_busy, b_sdi_ready});
        end
        tick();
        n_checks++;
        if ({b_err, b_busy, b_sdi_ready} !== 3'b000) begin
            n_fail++; $display("FAIL sel2_n2_after: err/busy/ready=%b required 000", {b_err, b_busy, b_sdi_ready});
        end
        n_checks++;
        if (tkx !== model) begin n_fail++; $display("FAIL sel3_tkx: got %h required %h", tkx, model); end
        $display("illegal select: err pulse, stayed idle");
    endtask

    task automatic test_reset_midload();
        ld_sel = 2'd0; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sdi_valid = 1'b1;
            sdi = D1[127-32*k -: 32];
            tick();
        end
        sdi_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        model = '0;
        n_checks++;
        if (tkx !== model) begin n_fail++; $display("FAIL midreset_tkx: got %h required 0", tkx); end
        n_checks++;
        if ({sdi_ready, busy, ld_done, err} !== 4'b0000) begin
            n_fail++; $display("FAIL midreset_ctrl: ready/busy/done/err=%b required 0000", {sdi_ready, busy, ld_done, err});
        end
        #2 rst = 1'b1;
        $display("reset mid-load: outputs cleared");
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load(2'd1, D1, 1'b0, 4, "load_cont");
        n_checks++;
        if (tkx[127:0] !== 128'h0 || tkx[383:256] !== 128'h0) begin
            n_fail++; $display("FAIL other_planes: p0=%h p2=%h required 0", tkx[127:0], tkx[383:256]);
        end
        test_load(2'd1, D1, 1'b1, 7, "load_gaps");
        test_back_to_back();
        test_abort(2'd2, 2, {64'h5A5A5A5A_5A5A5A5A, 32'hAAAA0001, 32'hBBBB0002}, "abort2");
        test_abort(2'd0, 3, {32'h5A5A5A5A, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003}, "abort_last");
        test_illegal_sel();
        test_reset_midload();
        test_load(2'd0, D1, 1'b0, 4, "fresh_load");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
